// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - req/ack bus between the MEM stage and the peripheral bridge
interface mem_stage_if;
   logic        pr_req;
   logic        pr_we;
   logic [31:0] pr_addr;
   logic [31:0] pr_wdata;
   logic [3:0]  pr_be;
   logic        pr_ack;
   logic [31:0] pr_rdata;

   modport master (output pr_req, pr_we, pr_addr, pr_wdata, pr_be,
                   input  pr_ack, pr_rdata);
   modport slave  (input  pr_req, pr_we, pr_addr, pr_wdata, pr_be,
                   output pr_ack, pr_rdata);
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS MEM stage: DM byte lanes, peripheral req/ack with timeout, MEM/WB register
module mem_stage #(
   parameter logic [15:0] PR_BASE = 16'h3000,
   parameter int          TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_ex_valid,
   input  logic [31:0] i_ex_addr,
   input  logic [31:0] i_ex_wdata,
   input  logic        i_ex_memread,
   input  logic        i_ex_memwrite,
   input  logic        i_ex_is_byte,
   input  logic        i_ex_is_half,
   input  logic [4:0]  i_ex_wb_ctrl,
   input  logic [4:0]  i_ex_rw,
   output logic [31:0] o_dm_addr,
   output logic [31:0] o_dm_wdata,
   output logic [3:0]  o_dm_be,
   mem_stage_if.master pr,
   output logic        o_mem_stall,
   output logic        o_wb_valid,
   output logic [31:0] o_wb_exout,
   output logic [4:0]  o_wb_rw,
   output logic [4:0]  o_wb_ctrl,
   output logic [31:0] o_wb_prrd,
   output logic        o_bus_err,
   output logic        o_align_err
);
   localparam int              CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [0:0]      S_IDLE   = 1'b0;
   localparam logic [0:0]      S_WAIT   = 1'b1;

   logic [0:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic          r_gap;
   logic          r_wb_valid;
   logic [31:0]   r_wb_exout;
   logic [4:0]    r_wb_rw;
   logic [4:0]    r_wb_ctrl;
   logic [31:0]   r_wb_prrd;

   logic          w_acc;
   logic          w_is_pr;
   logic          w_is_dm;
   logic          w_word;
   logic          w_mis;
   logic          w_pr_hit;
   logic          w_idle;
   logic          w_wait;
   logic          w_start;
   logic          w_hold;
   logic          w_expire;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata;

   assign w_acc    = i_ex_valid & (i_ex_memread | i_ex_memwrite);
   assign w_is_pr  = w_acc & (i_ex_addr[15:0] >= PR_BASE);
   assign w_is_dm  = w_acc & ~w_is_pr;
   assign w_word   = ~i_ex_is_byte & ~i_ex_is_half;
   assign w_mis    = w_acc & ((i_ex_is_half & ~i_ex_is_byte & i_ex_addr[0]) |
                              (w_word & (i_ex_addr[1:0] != 2'b00)));
   assign w_pr_hit = w_is_pr & ~w_mis;

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = i_ex_wdata;
      if (i_ex_is_byte) begin
         w_be    = 4'b0001 << i_ex_addr[1:0];
         w_wdata = {4{i_ex_wdata[7:0]}};
      end else if (i_ex_is_half) begin
         w_be    = i_ex_addr[1] ? 4'b1100 : 4'b0011;
         w_wdata = {2{i_ex_wdata[15:0]}};
      end
   end

   // A new request right after an ack is held off one cycle so pr_req visibly drops between accesses
   assign w_idle   = (r_state == S_IDLE);
   assign w_wait   = (r_state == S_WAIT);
   assign w_start  = rst & w_idle & w_pr_hit & ~r_gap;
   assign w_hold   = rst & w_idle & w_pr_hit & r_gap;
   assign w_expire = w_wait & (r_cnt == CNT_LAST);

   assign o_dm_addr   = i_ex_addr;
   assign o_dm_wdata  = w_wdata;
   assign o_dm_be     = (w_is_dm & i_ex_memwrite & ~w_mis) ? w_be : 4'b0000;

   assign pr.pr_req   = w_start | (w_wait & ~w_expire);
   assign pr.pr_we    = i_ex_memwrite;
   assign pr.pr_addr  = i_ex_addr;
   assign pr.pr_wdata = w_wdata;
   assign pr.pr_be    = w_be;

   assign o_mem_stall = w_start | w_hold | (w_wait & ~pr.pr_ack & ~w_expire);
   assign o_bus_err   = w_expire & ~pr.pr_ack;
   assign o_align_err = rst & w_idle & w_mis;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_gap      <= 1'b0;
         r_wb_valid <= 1'b0;
         r_wb_exout <= '0;
         r_wb_rw    <= '0;
         r_wb_ctrl  <= '0;
         r_wb_prrd  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_gap <= 1'b0;
               if (w_start || w_hold) begin
                  if (w_start) begin
                     r_state <= S_WAIT;
                     r_cnt   <= '0;
                  end
                  r_wb_valid <= 1'b0;
                  r_wb_ctrl  <= '0;
                  r_wb_prrd  <= '0;
               end else begin
                  r_wb_valid <= i_ex_valid;
                  r_wb_exout <= i_ex_addr;
                  r_wb_rw    <= i_ex_rw;
                  r_wb_ctrl  <= {i_ex_wb_ctrl[4] & i_ex_valid & ~w_mis, i_ex_wb_ctrl[3:0]};
                  r_wb_prrd  <= '0;
               end
            end
            default: begin
               r_cnt <= r_cnt + CW'(1);
               if (pr.pr_ack || w_expire) begin
                  r_state    <= S_IDLE;
                  r_gap      <= pr.pr_ack;
                  r_wb_valid <= 1'b1;
                  r_wb_exout <= i_ex_addr;
                  r_wb_rw    <= i_ex_rw;
                  r_wb_ctrl  <= {i_ex_wb_ctrl[4] & pr.pr_ack, i_ex_wb_ctrl[3:0]};
                  r_wb_prrd  <= (pr.pr_ack & ~i_ex_memwrite) ? pr.pr_rdata : 32'h0;
               end
            end
         endcase
      end
   end

   assign o_wb_valid = r_wb_valid;
   assign o_wb_exout = r_wb_exout;
   assign o_wb_rw    = r_wb_rw;
   assign o_wb_ctrl  = r_wb_ctrl;
   assign o_wb_prrd  = r_wb_prrd;
endmodule
